// File: rtl/axis_grant_mux_pkg.sv
// rtl/axis_grant_mux_pkg.sv - shared types for the grant-driven AXI-Stream mux
package axis_grant_mux_pkg;

    // Occupancy of the two-entry output register: output slot only, or output plus temp slot.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_grant_mux_skid.sv
// rtl/axis_grant_mux_skid.sv - 2-entry registered output stage (output reg + temp reg)
module axis_grant_mux_skid
    import axis_grant_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic [KEEP_WIDTH-1:0] in_tkeep,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    input  logic                  in_tlast,
    input  logic [USER_WIDTH-1:0] in_tuser,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic [KEEP_WIDTH-1:0] out_tkeep,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  out_tlast,
    output logic [USER_WIDTH-1:0] out_tuser
);

    skid_state_e state;
    skid_state_e state_next;

    logic load_out;
    logic load_temp;
    logic temp_to_out;

    logic [DATA_WIDTH-1:0] temp_tdata;
    logic [KEEP_WIDTH-1:0] temp_tkeep;
    logic                  temp_tlast;
    logic [USER_WIDTH-1:0] temp_tuser;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SKID_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // in_tvalid here is a completed upstream transfer, so it never arrives in SKID_TWO.
    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_temp   = 1'b0;
        temp_to_out = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (in_tvalid) begin
                    load_out   = 1'b1;
                    state_next = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (out_tready) begin
                    if (in_tvalid) begin
                        load_out = 1'b1;
                    end else begin
                        state_next = SKID_EMPTY;
                    end
                end else if (in_tvalid) begin
                    load_temp  = 1'b1;
                    state_next = SKID_TWO;
                end
            end
            SKID_TWO: begin
                if (out_tready) begin
                    temp_to_out = 1'b1;
                    state_next  = SKID_ONE;
                end
            end
            default: begin
                state_next = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tdata  <= '0;
            out_tkeep  <= '0;
            out_tlast  <= 1'b0;
            out_tuser  <= '0;
            temp_tdata <= '0;
            temp_tkeep <= '0;
            temp_tlast <= 1'b0;
            temp_tuser <= '0;
        end else begin
            if (load_out) begin
                out_tdata <= in_tdata;
                out_tkeep <= in_tkeep;
                out_tlast <= in_tlast;
                out_tuser <= in_tuser;
            end else if (temp_to_out) begin
                out_tdata <= temp_tdata;
                out_tkeep <= temp_tkeep;
                out_tlast <= temp_tlast;
                out_tuser <= temp_tuser;
            end
            if (load_temp) begin
                temp_tdata <= in_tdata;
                temp_tkeep <= in_tkeep;
                temp_tlast <= in_tlast;
                temp_tuser <= in_tuser;
            end
        end
    end

    assign out_tvalid = (state != SKID_EMPTY);
    assign in_tready  = (state != SKID_TWO);

endmodule

// File: rtl/axis_grant_mux.sv
// rtl/axis_grant_mux.sv - routes the arbiter-granted AXI-Stream input, frame by frame, to one output
module axis_grant_mux
    import axis_grant_mux_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [S_COUNT-1:0]            request,
    output logic [S_COUNT-1:0]            acknowledge,
    input  logic [S_COUNT-1:0]            grant,
    input  logic                          grant_valid,
    input  logic [$clog2(S_COUNT)-1:0]    grant_encoded,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser
);

    localparam int CL_S_COUNT = $clog2(S_COUNT);

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_WIDTH-1:0] sel_tkeep;
    logic                  sel_tlast;
    logic [USER_WIDTH-1:0] sel_tuser;

    logic                  skid_ready;
    logic                  accept_en;
    logic [S_COUNT-1:0]    xfer;

    always_comb begin
        sel_tdata = '0;
        sel_tkeep = '1;
        sel_tlast = 1'b0;
        sel_tuser = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_encoded == i[CL_S_COUNT-1:0]) begin
                sel_tdata = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tlast = s_axis_tlast[i];
                sel_tuser = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                if (KEEP_ENABLE != 0) begin
                    sel_tkeep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                end
            end
        end
    end

    // skid_ready comes from a register, so m_axis_tready never reaches s_axis_tready combinationally.
    assign accept_en     = rst_n & grant_valid & skid_ready;
    assign s_axis_tready = grant & {S_COUNT{accept_en}};
    assign xfer          = s_axis_tready & s_axis_tvalid;
    assign acknowledge   = xfer & s_axis_tlast;
    assign request       = s_axis_tvalid;

    axis_grant_mux_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_tdata   (sel_tdata),
        .in_tkeep   (sel_tkeep),
        .in_tvalid  (|xfer),
        .in_tready  (skid_ready),
        .in_tlast   (sel_tlast),
        .in_tuser   (sel_tuser),
        .out_tdata  (m_axis_tdata),
        .out_tkeep  (m_axis_tkeep),
        .out_tvalid (m_axis_tvalid),
        .out_tready (m_axis_tready),
        .out_tlast  (m_axis_tlast),
        .out_tuser  (m_axis_tuser)
    );

    // Open-frame tracking only feeds the grant-stability assertions below.
    logic                  frame_open;
    logic [CL_S_COUNT-1:0] open_port;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_open <= 1'b0;
            open_port  <= '0;
        end else if (|xfer) begin
            frame_open <= ~(|acknowledge);
            open_port  <= grant_encoded;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_grant_held: assert property (@(posedge clk) disable iff (!rst_n)
        frame_open |-> (grant_valid && grant_encoded == open_port));

endmodule

// File: tb/tb_axis_grant_mux.sv
// tb/tb_axis_grant_mux.sv - scoreboard bench with a round-robin acknowledge-blocking arbiter
module tb_axis_grant_mux;
    localparam int S  = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } ack_ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]    request, acknowledge, grant;
    logic          grant_valid;
    logic [1:0]    grant_encoded;
    logic [S*DW-1:0] s_tdata;
    logic [3:0]    s_tkeep, s_tvalid, s_tready, s_tlast, s_tuser;
    logic [DW-1:0] m_tdata;
    logic [0:0]    m_tkeep;
    logic          m_tvalid, m_tready, m_tlast;
    logic [0:0]    m_tuser;

    axis_grant_mux #(.S_COUNT(S), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
    );

    // Wide instance with keep disabled and a fixed grant to port 1.
    logic [3:0]   req32, ack32;
    logic [127:0] s32_tdata;
    logic [3:0]   s32_tvalid, s32_tready, s32_tlast;
    logic [31:0]  m32_tdata;
    logic [3:0]   m32_tkeep;
    logic         m32_tvalid, m32_tready, m32_tlast;
    logic [0:0]   m32_tuser;

    axis_grant_mux #(.S_COUNT(4), .DATA_WIDTH(32), .KEEP_ENABLE(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .request(req32), .acknowledge(ack32),
        .grant(4'b0010), .grant_valid(1'b1), .grant_encoded(2'd1),
        .s_axis_tdata(s32_tdata), .s_axis_tkeep(16'h0000), .s_axis_tvalid(s32_tvalid),
        .s_axis_tready(s32_tready), .s_axis_tlast(s32_tlast), .s_axis_tuser(4'b0000),
        .m_axis_tdata(m32_tdata), .m_axis_tkeep(m32_tkeep), .m_axis_tvalid(m32_tvalid),
        .m_axis_tready(m32_tready), .m_axis_tlast(m32_tlast), .m_axis_tuser(m32_tuser)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Round-robin arbiter that holds a grant until that port acknowledges.
    logic [1:0] rr_last;
    always @(posedge clk or negedge rst_n) begin : arb
        logic [3:0] cand;
        int pick;
        if (!rst_n) begin
            grant <= 4'b0; grant_valid <= 1'b0; grant_encoded <= 2'd0; rr_last <= 2'd3;
        end else if (!grant_valid || (|(acknowledge & grant))) begin
            cand = request & ~acknowledge;
            pick = -1;
            for (int k = 1; k <= 4; k++)
                if (pick < 0 && cand[(int'(rr_last) + k) % 4]) pick = (int'(rr_last) + k) % 4;
            if (pick >= 0) begin
                grant <= 4'b1 << pick; grant_valid <= 1'b1;
                grant_encoded <= 2'(pick); rr_last <= 2'(pick);
            end else begin
                grant <= 4'b0; grant_valid <= 1'b0;
            end
        end
    end

    beat_t txq[S][$];
    beat_t expq[S][$];
    int exp_order[$];
    ack_ev_t ack_log[$];
    logic [3:0] presenting = '0;
    logic [3:0] hs_s = '0;
    bit gap_en = 0;
    bit rand_ready = 0;
    int occ = 0;
    int temp_full_seen = 0;
    int frames_out = 0;
    int ack_total = 0;
    int acc_cnt[S] = '{default: 0};
    bit in_frame = 0;
    logic [1:0] cur_port = 0;
    logic [5:0] seq[S] = '{default: 6'd0};

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < S; p++) begin
            if (presenting[p] && hs_s[p]) begin
                if (txq[p].size() > 0) txq[p].delete(0);
                presenting[p] = 1'b0;
            end
            if (rst_n && !presenting[p] && txq[p].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0))
                presenting[p] = 1'b1;
            s_tvalid[p] = presenting[p];
            if (presenting[p]) begin
                s_tdata[p*DW +: DW] = txq[p][0].data;
                s_tlast[p] = txq[p][0].last;
                s_tuser[p] = txq[p][0].user;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_ready) m_tready = ($urandom_range(0, 9) < 7);
    end

    // Scoreboard/monitor: abstract occupancy model plus per-port expected beat queues.
    always @(negedge clk) begin : mon
        logic [3:0] hs;
        beat_t e;
        if (!rst_n) begin
            occ = 0; hs_s = '0;
        end else begin
            hs = s_tvalid & s_tready;
            hs_s = hs;
            if ((|hs) || (|acknowledge)) check("ack_vs_last_beat", acknowledge, hs & s_tlast);
            if (|acknowledge) begin
                ack_log.push_back('{cyc, acknowledge});
                ack_total += $countones(acknowledge);
            end
            check("m_valid_vs_occupancy", m_tvalid, occ > 0);
            if (grant_valid) check("s_ready_granted", s_tready, (occ < 2) ? grant : 4'b0);
            else check("s_ready_no_grant", s_tready, 4'b0);
            if (occ == 2) temp_full_seen++;
            for (int p = 0; p < S; p++) if (hs[p]) acc_cnt[p]++;
            if (m_tvalid && m_tready) begin
                if (!in_frame) begin
                    cur_port = m_tdata[7:6];
                    in_frame = 1;
                    if (exp_order.size() > 0) check("frame_order", cur_port, exp_order.pop_front());
                end else begin
                    check("no_interleave", m_tdata[7:6], cur_port);
                end
                if (expq[cur_port].size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = expq[cur_port].pop_front();
                    check("tdata", m_tdata, e.data);
                    check("tlast", m_tlast, e.last);
                    check("tuser", m_tuser, e.user);
                end
                check("tkeep_ones", m_tkeep, 1'b1);
                if (m_tlast) begin
                    in_frame = 0;
                    frames_out++;
                end
            end
            occ += ((|hs) ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
        end
    end

    logic [31:0] q32[$];
    logic        l32[$];
    always @(negedge clk) begin
        if (rst_n && m32_tvalid && m32_tready) begin
            if (q32.size() == 0) begin
                check("w32_unexpected_beat", 1, 0);
            end else begin
                check("w32_tdata", m32_tdata, q32.pop_front());
                check("w32_tlast", m32_tlast, l32.pop_front());
            end
            check("w32_tkeep_all_ones", m32_tkeep, 4'hF);
        end
    end

    task automatic send_frame(input int p, input int n, input logic [5:0] low, input bit rnd_user);
        beat_t b;
        logic [5:0] lo;
        for (int i = 0; i < n; i++) begin
            lo = low + i[5:0];
            b.data = {2'(p), lo};
            b.last = (i == n - 1);
            b.user = rnd_user ? 1'($urandom_range(0, 1)) : 1'b0;
            txq[p].push_back(b);
            expq[p].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < S; p++) if (expq[p].size() != 0 || txq[p].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (n < max_cyc && !(all_empty() && occ == 0)) begin
            @(posedge clk);
            n++;
        end
        check("drain_within_budget", n < max_cyc, 1);
        @(posedge clk); #3;
    endtask

    task automatic do_reset();
        rst_n = 0;
        for (int p = 0; p < S; p++) begin
            txq[p].delete(); expq[p].delete();
        end
        exp_order.delete();
        presenting = '0; s_tvalid = '0; in_frame = 0;
        #1;
        check("reset_m_valid", m_tvalid, 0);
        check("reset_s_ready", s_tready, 4'b0);
        check("reset_ack", acknowledge, 4'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int xf, ov, f0, nfr, a0;
        logic [3:0] pat;
        logic [31:0] d;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        s32_tdata = '0; s32_tvalid = '0; s32_tlast = '0;
        m_tready = 1; m32_tready = 1;
        repeat (3) @(posedge clk);
        #3;
        check("reset_m_valid_init", m_tvalid, 0);
        check("reset_m_data_init", m_tdata, 8'h00);
        check("reset_s_ready_init", s_tready, 4'b0);
        check("reset_m32_valid_init", m32_tvalid, 0);
        rst_n = 1;

        // 1: reset in the middle of a frame, then resend it
        @(posedge clk); #3;
        send_frame(0, 3, 6'h10, 0);
        for (int i = 0; i < 50 && acc_cnt[0] < 1; i++) @(posedge clk);
        #3;
        check("t1_first_beat_taken", acc_cnt[0] >= 1, 1);
        do_reset();
        f0 = frames_out;
        send_frame(0, 3, 6'h10, 0);
        wait_idle(200);
        check("t1_frame_after_reset", frames_out - f0, 1);

        // 2: single 4-beat frame on port 2
        ack_log.delete();
        send_frame(2, 4, 6'h20, 0);
        xf = -1; ov = -1;
        for (int i = 0; i < 40 && ov < 0; i++) begin
            @(negedge clk);
            if (xf < 0 && s_tvalid[2] && s_tready[2]) xf = cyc;
            if (ov < 0 && m_tvalid) ov = cyc;
        end
        check("t2_first_beat_latency", ov - xf, 1);
        @(posedge clk); #3;
        wait_idle(200);
        check("t2_ack_pulses", ack_log.size(), 1);
        if (ack_log.size() > 0) check("t2_ack_vector", ack_log[0].vec, 4'b0100);

        // 3: three ports contend, round-robin from reset
        do_reset();
        ack_log.delete();
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(3);
        send_frame(0, 2, 6'h00, 1);
        send_frame(1, 2, 6'h00, 1);
        send_frame(3, 2, 6'h00, 1);
        wait_idle(200);
        check("t3_ack_pulses", ack_log.size(), 3);
        check("t3_order_consumed", exp_order.size(), 0);

        // 4: backpressure pattern 1,0,0,1 across an 8-beat frame
        temp_full_seen = 0;
        send_frame(1, 8, 6'h00, 1);
        pat = 4'b1001;
        for (int i = 0; i < 24; i++) begin
            m_tready = pat[i % 4];
            @(posedge clk); #3;
        end
        m_tready = 1;
        wait_idle(200);
        check("t4_temp_slot_used", temp_full_seen > 0, 1);

        // 5: back-to-back single-beat frames on ports 0 and 1
        ack_log.delete();
        send_frame(0, 1, 6'h05, 0);
        send_frame(1, 1, 6'h05, 0);
        wait_idle(200);
        check("t5_ack_pulses", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("t5_first_ack", ack_log[0].vec, 4'b0001);
            check("t5_second_ack", ack_log[1].vec, 4'b0010);
            check("t5_ack_spacing", ack_log[1].cyc - ack_log[0].cyc, 1);
        end

        // 6: 32-bit instance, keep disabled, keep inputs all zero
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 3; b++) begin
                d = $urandom;
                s32_tdata[32 +: 32] = d;
                s32_tlast[1] = (b == 2);
                s32_tvalid[1] = 1;
                q32.push_back(d); l32.push_back(b == 2);
                xf = 0;
                for (int i = 0; i < 50 && xf == 0; i++) begin
                    @(negedge clk);
                    if (s32_tready[1]) xf = 1;
                end
                check("t6_beat_accepted", xf, 1);
                @(posedge clk); #3;
                s32_tvalid[1] = 0;
            end
        end
        repeat (4) @(posedge clk);
        #3;
        check("t6_all_beats_out", q32.size(), 0);

        // 7: randomized traffic with gaps and random output stalls
        gap_en = 1; rand_ready = 1;
        a0 = ack_total; f0 = frames_out; nfr = 0;
        for (int f = 0; f < 60; f++) begin
            int p, len;
            p = $urandom_range(0, 3);
            len = $urandom_range(1, 6);
            send_frame(p, len, seq[p], 1);
            seq[p] = seq[p] + 6'(len);
            nfr++;
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #3;
        end
        wait_idle(5000);
        rand_ready = 0; m_tready = 1; gap_en = 0;
        check("t7_frames_out", frames_out - f0, nfr);
        check("t7_ack_count", ack_total - a0, nfr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
